// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer for the fetch stage, with a sweep FSM that invalidates the whole table.
// Latency: lookup is combinational (0 cycles); an update becomes visible on the cycle after it is presented.
// Backpressure: none. While a sweep runs (o_busy=1), lookups miss and updates are silently dropped.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_lookup_pc -> o_pred_taken / o_pred_target   same-cycle prediction for the PC being fetched
//   i_update_en/_pc/_target/_taken                branch/jump resolution coming back from decode
//   i_flush_req -> o_busy                         starts (or restarts) the invalidation sweep
// Optional feature: define BTB_2BIT_CTR_EN to give each entry a 2-bit saturating counter.
module btb_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lookup_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_update_en,
    input  logic [31:0] i_update_pc,
    input  logic [31:0] i_update_target,
    input  logic        i_update_taken,
    input  logic        i_flush_req,
    output logic        o_busy
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic               w_sweeping;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
`ifdef BTB_2BIT_CTR_EN
    logic [1:0]         r_ctr    [ENTRIES];
`endif

    // PC field split: word-aligned, so bits [1:0] never take part
    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_unused_pc_lsbs;

    assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
    assign w_lk_tag = i_lookup_pc[31:IDX_W+2];
    assign w_up_idx = i_update_pc[IDX_W+1:2];
    assign w_up_tag = i_update_pc[31:IDX_W+2];
    assign w_unused_pc_lsbs = ^{i_lookup_pc[1:0], i_update_pc[1:0]};

    // ------------------------------------------------------------------
    // Sweep FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_flush_req) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                // A new request restarts the sweep, so it takes precedence over the end test
                if (i_flush_req) begin
                    w_state_nxt = ST_SWEEP;
                end else if (r_ptr == LAST_IDX) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sweeping = (r_state == ST_SWEEP);
        o_busy     = w_sweeping;
    end

    // The pointer stops at the last entry rather than wrapping; a new request always reloads it with 0
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ptr <= '0;
        end else if (i_flush_req) begin
            r_ptr <= '0;
        end else if (w_sweeping && (r_ptr != LAST_IDX)) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic w_upd_act;
    logic w_up_hit;
    logic w_set_valid;
    logic w_clr_valid;

    assign w_upd_act = i_update_en && !w_sweeping;
    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

`ifdef BTB_2BIT_CTR_EN
    // The counter absorbs not-taken outcomes, so the entry itself stays valid
    assign w_set_valid = w_upd_act && i_update_taken;
    assign w_clr_valid = 1'b0;
`else
    assign w_set_valid = w_upd_act && i_update_taken;
    assign w_clr_valid = w_upd_act && !i_update_taken && w_up_hit;
`endif

    // Sweep and updates never overlap, because updates are dropped while sweeping
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_valid <= '0;
        end else if (w_sweeping) begin
            r_valid[r_ptr] <= 1'b0;
        end else if (w_set_valid) begin
            r_valid[w_up_idx] <= 1'b1;
        end else if (w_clr_valid) begin
            r_valid[w_up_idx] <= 1'b0;
        end
    end

    // Payload arrays carry no reset; they are meaningless while the entry is invalid
    always_ff @(posedge i_clk) begin
        if (w_upd_act && i_update_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= i_update_target;
        end
    end

`ifdef BTB_2BIT_CTR_EN
    always_ff @(posedge i_clk) begin
        if (w_upd_act) begin
            if (i_update_taken) begin
                if (!w_up_hit) begin
                    r_ctr[w_up_idx] <= 2'b10;
                end else if (r_ctr[w_up_idx] != 2'b11) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
                end
            end else if (w_up_hit && (r_ctr[w_up_idx] != 2'b00)) begin
                r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Lookup path: reads the registered state only, so an update in the same cycle is not seen
    // ------------------------------------------------------------------
    logic w_lk_hit;
    logic w_pred;

    assign w_lk_hit = !w_sweeping && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

`ifdef BTB_2BIT_CTR_EN
    assign w_pred = w_lk_hit && r_ctr[w_lk_idx][1];
`else
    assign w_pred = w_lk_hit;
`endif

    assign o_pred_taken  = w_pred;
    assign o_pred_target = w_pred ? r_target[w_lk_idx] : 32'h0;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: lookups, updates, and flush sweeps (including restart and reset mid-sweep).
// Inputs are driven 1 time unit after the rising edge; outputs are checked in that same window.
// Expected values are hand-derived for ENTRIES=16 (idx = pc[5:2], tag = pc[31:6]).
module tb_btb_predictor;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_lookup_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_update_en;
    logic [31:0] i_update_pc;
    logic [31:0] i_update_target;
    logic        i_update_taken;
    logic        i_flush_req;
    logic        o_busy;

    int n_cmp;
    int n_bad;
    int n_busy;

    btb_predictor #(.ENTRIES(16)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_lookup_pc     (i_lookup_pc),
        .o_pred_taken    (o_pred_taken),
        .o_pred_target   (o_pred_target),
        .i_update_en     (i_update_en),
        .i_update_pc     (i_update_pc),
        .i_update_target (i_update_target),
        .i_update_taken  (i_update_taken),
        .i_flush_req     (i_flush_req),
        .o_busy          (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Lookup expectation: hit flag and target
    task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit, input logic [31:0] exp_tgt);
        i_lookup_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'b0, o_pred_taken}, {31'b0, exp_hit});
        chk({tag, "_target"}, o_pred_target, exp_tgt);
    endtask

    // One-cycle update
    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        i_update_en     = 1'b1;
        i_update_pc     = pc;
        i_update_target = tgt;
        i_update_taken  = taken;
        tick();
        i_update_en     = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        i_reset         = 1'b0;
        i_lookup_pc     = 32'h40;
        i_update_en     = 1'b0;
        i_update_pc     = 32'h0;
        i_update_target = 32'h0;
        i_update_taken  = 1'b0;
        i_flush_req     = 1'b0;

        // 1. reset state
        #3;
        look("rst", 32'h40, 1'b0, 32'h0);
        chk("rst_busy", {31'b0, o_busy}, 32'h0);
        #8;
        i_reset = 1'b1;
        tick();
        look("post_rst", 32'h40, 1'b0, 32'h0);

        // 2/3. update and same-cycle lookup sees old contents; next cycle hits
        i_update_en     = 1'b1;
        i_update_pc     = 32'h40;
        i_update_target = 32'h100;
        i_update_taken  = 1'b1;
        look("same_cyc", 32'h40, 1'b0, 32'h0);
        tick();
        i_update_en = 1'b0;
        look("hit40", 32'h40, 1'b1, 32'h100);
        look("alias440", 32'h440, 1'b0, 32'h0);

        // not-taken update with non-matching tag leaves entry untouched
        upd(32'h440, 32'h0, 1'b0);
        look("nt_other_tag", 32'h40, 1'b1, 32'h100);

        // 4. populate again, then not-taken updates
        upd(32'h40, 32'h100, 1'b1);
        upd(32'h40, 32'h0, 1'b0);
`ifdef BTB_2BIT_CTR_EN
        look("nt1_ctr", 32'h40, 1'b1, 32'h100);
        upd(32'h40, 32'h0, 1'b0);
        look("nt2_ctr", 32'h40, 1'b0, 32'h0);
`else
        look("nt1", 32'h40, 1'b0, 32'h0);
`endif

        // 5. populate idx 0..3, sweep
        upd(32'h00, 32'h200, 1'b1);
        upd(32'h04, 32'h204, 1'b1);
        upd(32'h08, 32'h208, 1'b1);
        upd(32'h0C, 32'h20C, 1'b1);
        look("pop04", 32'h04, 1'b1, 32'h204);
        look("pop0C", 32'h0C, 1'b1, 32'h20C);
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        i_lookup_pc = 32'h0C;
        n_busy = 0;
        while (o_busy && n_busy < 40) begin
            // idx3 has not been reached by the sweep yet, but lookups must still miss
            if (n_busy == 1) look("sweep_look", 32'h0C, 1'b0, 32'h0);
            // idx2 is already cleared here; a leaked update would make it valid again
            if (n_busy == 10) begin
                i_update_en     = 1'b1;
                i_update_pc     = 32'h08;
                i_update_target = 32'h999;
                i_update_taken  = 1'b1;
            end else begin
                i_update_en = 1'b0;
            end
            n_busy++;
            tick();
        end
        i_update_en = 1'b0;
        chk("sweep_len", n_busy, 32'd16);
        look("after00", 32'h00, 1'b0, 32'h0);
        look("after04", 32'h04, 1'b0, 32'h0);
        look("after08", 32'h08, 1'b0, 32'h0);
        look("after0C", 32'h0C, 1'b0, 32'h0);

        // update works again once idle
        upd(32'h10, 32'h300, 1'b1);
        look("idle_upd", 32'h10, 1'b1, 32'h300);

        // 6. restart at sweep cycle 5 -> 5 + 16 busy cycles
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        n_busy = 0;
        while (o_busy && n_busy < 60) begin
            i_flush_req = (n_busy == 4);
            n_busy++;
            tick();
        end
        i_flush_req = 1'b0;
        chk("restart_len", n_busy, 32'd21);

        // reset mid-sweep: idx15 is never reached by the sweep, so only reset can clear it
        upd(32'h3C, 32'h400, 1'b1);
        look("pop3C", 32'h3C, 1'b1, 32'h400);
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        tick();
        tick();
        chk("mid_busy", {31'b0, o_busy}, 32'h1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, o_busy}, 32'h0);
        #1;
        i_reset = 1'b1;
        tick();
        chk("rst_idle_busy", {31'b0, o_busy}, 32'h0);
        look("rst_clr3C", 32'h3C, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
